// File: rtl/instruction_loader.sv
// instruction_loader
//   Boot-time writer for the instruction memory of the pipelined MIPS core.
//   It receives a byte stream that starts with a 16-bit word-count header,
//   followed by big-endian instruction words. Each word is written to the
//   next consecutive instruction-memory address. The core is held until the
//   whole program has been loaded.
//
//   Optional feature: define LOADER_CHECKSUM_EN to add a CSUM state. In that
//   state one extra byte is received and compared with the XOR of all data
//   bytes. A match goes to DONE and a mismatch goes to ERR.
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high reset
//   in_data     incoming byte
//   in_valid    in_data valid
//   in_ready    a byte is accepted this cycle (transfer = in_valid & in_ready)
//   imem_we     instruction-memory write strobe, one-cycle pulse per word
//   imem_addr   instruction-memory byte address (word aligned)
//   imem_wdata  instruction word to write
//   cpu_hold    1 = core held, 0 = core runs
//   load_done   program loaded successfully (sticky until reset)
//   load_err    load failed (sticky until reset)
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  // State reached once the payload is complete (or the count is zero).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN_STATE = CSUM;
`else
  localparam state_t FIN_STATE = DONE;
`endif

  state_t                 state, state_nxt;
  logic [7:0]             hdr_hi, hdr_hi_nxt;
  logic [CNT_WIDTH-1:0]   count, count_nxt;
  logic [CNT_WIDTH-1:0]   word_cnt, word_cnt_nxt;
  logic [1:0]             byte_idx, byte_idx_nxt;
  logic [23:0]            word_buf, word_buf_nxt;
  logic                   ready_nxt, we_nxt;
  logic [31:0]            addr_nxt, wdata_nxt;
  logic [15:0]            hdr;
  logic                   xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum, csum_nxt;
`endif

  assign xfer = in_valid & in_ready;
  assign hdr  = {hdr_hi, in_data};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= LEN_HI;
    else       state <= state_nxt;
  end

  // Next-state, datapath and output-register next values
  always_comb begin
    state_nxt    = state;
    hdr_hi_nxt   = hdr_hi;
    count_nxt    = count;
    word_cnt_nxt = word_cnt;
    byte_idx_nxt = byte_idx;
    word_buf_nxt = word_buf;
    we_nxt       = 1'b0;
    wdata_nxt    = imem_wdata;
    // The address advances once the write pulse has been issued.
    addr_nxt     = imem_we ? imem_addr + 32'd4 : imem_addr;
`ifdef LOADER_CHECKSUM_EN
    csum_nxt     = csum;
`endif

    unique case (state)
      LEN_HI: begin
        if (xfer) begin
          hdr_hi_nxt = in_data;
          state_nxt  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          count_nxt    = CNT_WIDTH'(hdr);
          word_cnt_nxt = '0;
          byte_idx_nxt = 2'd0;
          if (hdr == 16'd0)                state_nxt = FIN_STATE;
          else if (32'(hdr) > MAX_WORDS)   state_nxt = ERR;
          else                             state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          byte_idx_nxt = byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_nxt = csum ^ in_data;
`endif
          unique case (byte_idx)
            2'd0: word_buf_nxt[23:16] = in_data;
            2'd1: word_buf_nxt[15:8]  = in_data;
            2'd2: word_buf_nxt[7:0]   = in_data;
            2'd3: begin
              wdata_nxt    = {word_buf, in_data};
              we_nxt       = 1'b1;
              word_cnt_nxt = word_cnt + CNT_WIDTH'(1);
            end
            default: ;
          endcase
        end
        // Leave only after the final write pulse has gone out.
        if (imem_we && (word_cnt == count)) state_nxt = FIN_STATE;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
      end
`endif
      DONE: ;
      ERR:  ;
      default: state_nxt = ERR;
    endcase

    // Stop accepting bytes once the last data word has been received.
    ready_nxt = (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
`ifdef LOADER_CHECKSUM_EN
                (state_nxt == CSUM) ||
`endif
                ((state_nxt == DATA) && (word_cnt_nxt != count_nxt));
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi     <= 8'h00;
      count      <= '0;
      word_cnt   <= '0;
      byte_idx   <= 2'd0;
      word_buf   <= 24'h0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      hdr_hi     <= hdr_hi_nxt;
      count      <= count_nxt;
      word_cnt   <= word_cnt_nxt;
      byte_idx   <= byte_idx_nxt;
      word_buf   <= word_buf_nxt;
      in_ready   <= ready_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= wdata_nxt;
      cpu_hold   <= (state_nxt != DONE);
      load_done  <= (state_nxt == DONE);
      load_err   <= (state_nxt == ERR);
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//   Self-checking bench for instruction_loader. It runs a vector table of
//   headers and words, then hand-written sequences that reset mid-load and
//   exercise the checksum. Expected memory writes go into a scoreboard queue
//   and are matched when imem_we pulses. Define LOADER_CHECKSUM_EN for both
//   the bench and the RTL together.
module tb_instruction_loader;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, imem_we, cpu_hold, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;

  instruction_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          wcyc;
  } wr_t;
  wr_t sb[$];
  wr_t exp_wr;

  typedef struct {
    logic [15:0] hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;
    bit          exp_done;
    bit          exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Write monitor: every pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        exp_wr = sb.pop_front();
        chk("wr_addr", imem_addr, exp_wr.addr);
        chk("wr_data", imem_wdata, exp_wr.data);
        chk("wr_latency_cycle", 32'(cyc), 32'(exp_wr.wcyc));
        chk("hold_during_write", {30'h0, cpu_hold, load_done}, 32'h2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_imem_we", 32'(imem_we), 32'h0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk("rst_flags_hold_done_err", {29'h0, cpu_hold, load_done, load_err}, 32'h4);
    reset = 1'b0;
    tick();
  endtask

  // Hold in_valid until the byte is taken. xc is the cycle count after the
  // transfer edge, which is the cycle in which a resulting write must pulse.
  task automatic send_byte(input logic [7:0] b, output int xc);
    int n;
    n = 0;
    xc = -1;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles, required 1 (byte %h)", b);
    end else begin
      @(posedge clk);
      #1;
      xc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
    int xc;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], xc);
      if (i == 3 && xc >= 0) sb.push_back('{addr: addr, data: w, wcyc: xc});
      if (gap) tick();
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(load_done || load_err) && n < 40) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int k);
    if (k == 0) return v.w0;
    if (k == 1) return v.w1;
    return v.w1 ^ (32'(k) * 32'h9E3779B9);
  endfunction

  task automatic check_end(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done_err"}, {30'h0, load_done, load_err}, {30'h0, exp_done, exp_err});
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    tick();
    chk({tag, "_pending_writes"}, 32'(sb.size()), 32'h0);
    // Further input must be ignored.
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk({tag, "_post_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_post_flags"}, {30'h0, load_done, load_err}, {30'h0, exp_done, exp_err});
  endtask

  initial begin
    int xc;
    int nw;
    logic [7:0] cs;
    logic [31:0] w;

    vecs[0] = '{16'h0002, 32'h20080005, 32'h8D090004, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0101, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h0001, 32'h12345678, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h0003, 32'hDEADBEEF, 32'h0F1E2D3C, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0100, 32'hCAFEF00D, 32'h00000001, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h0200, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      cs = 8'h00;
      send_byte(vecs[v].hdr[15:8], xc);
      send_byte(vecs[v].hdr[7:0], xc);
      nw = vecs[v].exp_err ? 0 : int'(vecs[v].hdr);
      for (int k = 0; k < nw; k++) begin
        w  = word_of(vecs[v], k);
        cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        send_word(w, BASE + 32'(4 * k), vecs[v].gap);
      end
`ifdef LOADER_CHECKSUM_EN
      if (!vecs[v].exp_err) send_byte(cs, xc);
`endif
      wait_end();
      check_end($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
    end

    // Reset after two data bytes, then a clean reload.
    do_reset();
    send_byte(8'h00, xc);
    send_byte(8'h01, xc);
    send_byte(8'h11, xc);
    send_byte(8'h22, xc);
    do_reset();
    send_byte(8'h00, xc);
    send_byte(8'h01, xc);
    send_word(32'hAABBCCDD, BASE, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, xc);
`endif
    wait_end();
    check_end("reload", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    for (int m = 0; m < 2; m++) begin
      do_reset();
      send_byte(8'h00, xc);
      send_byte(8'h01, xc);
      send_word(32'h01020408, BASE, 1'b0);
      send_byte((m == 0) ? 8'h0F : 8'h0E, xc);
      wait_end();
      check_end((m == 0) ? "csum_ok" : "csum_bad", m == 0, m == 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

endmodule
